// File: rtl/jtpang_pkg.sv
// ---------------------------------------------------------------------------
// jtpang_pkg
// Shared constants and FSM state encoding for the object line buffer.
//   OBJ_BLANK   : pixel value meaning "nothing drawn here"
//   OBJ_LINE_W  : columns per line bank
//   obj_state_t : line-buffer controller states (CHECK only exists when
//                 JTPANG_OBJBUF_PRIO_EN is defined)
// ---------------------------------------------------------------------------
package jtpang_pkg;

    localparam logic [7:0] OBJ_BLANK  = 8'hFF;
    localparam int         OBJ_LINE_W = 512;
    localparam int         OBJ_COL_AW = $clog2(OBJ_LINE_W);
    localparam int         OBJ_RAM_AW = OBJ_COL_AW + 1;
    localparam logic [3:0] OBJ_TRANSP = 4'hF;

`ifdef JTPANG_OBJBUF_PRIO_EN
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CHECK = 2'd2
    } obj_state_t;
`else
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1
    } obj_state_t;
`endif

    // A pixel whose colour nibble is all ones is see-through
    function automatic logic is_opaque(input logic [7:0] pxl);
        return pxl[3:0] != OBJ_TRANSP;
    endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// ---------------------------------------------------------------------------
// jtframe_dual_ram
// Two-port synchronous RAM, one clock, registered read data (old data is
// returned when a port reads and writes the same cycle).
//   i_clk            : clock
//   i_addr0/i_data0  : port 0 address / write data
//   i_we0            : port 0 write enable
//   o_q0             : port 0 read data, one clk after the address
//   i_addr1/i_data1  : port 1 address / write data
//   i_we1            : port 1 write enable
//   o_q1             : port 1 read data, one clk after the address
// When both ports write the same word in one cycle, port 0 wins.
// ---------------------------------------------------------------------------
module jtframe_dual_ram #(
    parameter int dw = 8,
    parameter int aw = 10
) (
    input  logic          i_clk,
    input  logic [aw-1:0] i_addr0,
    input  logic [dw-1:0] i_data0,
    input  logic          i_we0,
    output logic [dw-1:0] o_q0,
    input  logic [aw-1:0] i_addr1,
    input  logic [dw-1:0] i_data1,
    input  logic          i_we1,
    output logic [dw-1:0] o_q1
);

    logic [dw-1:0] r_mem [0:(1<<aw)-1];

    // Port 1 is written first so a same-address port 0 write overrides it
    always_ff @(posedge i_clk) begin
        if (i_we1) r_mem[i_addr1] <= i_data1;
        if (i_we0) r_mem[i_addr0] <= i_data0;
        o_q0 <= r_mem[i_addr0];
        o_q1 <= r_mem[i_addr1];
    end

endmodule

// File: rtl/jtpang_objbuf.sv
// ---------------------------------------------------------------------------
// jtpang_objbuf
// Double-buffered object line buffer. One 512-pixel bank is scanned out
// (and erased behind the beam) while the other is drawn; the banks swap at
// the start of every horizontal blank.
//   clk       : video clock
//   rst_n     : asynchronous active-low reset
//   pxl_cen   : pixel clock enable (at most one every 3 clk)
//   LHBL      : active-low horizontal blank
//   hdump     : read-side column
//   buf_we    : draw-side write request
//   buf_addr  : draw-side column
//   buf_data  : draw-side pixel {palette, colour}
//   buf_ok    : draw side may write this cycle
//   obj_pxl   : pixel to the mixer, colour 4'hF = transparent
//   line      : bank currently being read
// Build option: JTPANG_OBJBUF_PRIO_EN selects first-drawn-wins priority
// (read-check-write, 2 clk per write); otherwise the last write wins.
// ---------------------------------------------------------------------------
module jtpang_objbuf
    import jtpang_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pxl_cen,
    input  logic       LHBL,
    input  logic [8:0] hdump,
    input  logic       buf_we,
    input  logic [8:0] buf_addr,
    input  logic [7:0] buf_data,
    output logic       buf_ok,
    output logic [7:0] obj_pxl,
    output logic       line
);

    logic       r_lhbl_l;
    logic       r_line;
    logic       r_rd_pend;
    logic [9:0] r_erase_addr;
    logic [9:0] r_clr_addr;
    logic [7:0] r_pxl_next;
    logic [7:0] r_obj_pxl;
    obj_state_t r_state;
    obj_state_t w_next_state;

    logic       w_hb_fall;
    logic [9:0] w_addr0;
    logic       w_we0;
    logic [7:0] w_q0;
    logic [9:0] w_draw_addr;
    logic [9:0] w_addr1;
    logic [7:0] w_data1;
    logic       w_we1;
    logic [7:0] w_q1;
    logic       w_buf_ok;

`ifdef JTPANG_OBJBUF_PRIO_EN
    logic [9:0] r_chk_addr;
    logic [7:0] r_chk_data;
`else
    logic       w_unused_q1;
    assign w_unused_q1 = ^w_q1;
`endif

    assign w_hb_fall   = r_lhbl_l & ~LHBL;
    // Draw target uses the pre-swap bank, so a write in the swap cycle
    // lands in the bank about to be read
    assign w_draw_addr = {~r_line, buf_addr};

    // Port 0 reads on pxl_cen and erases the same word on the next clk
    assign w_addr0 = r_rd_pend ? r_erase_addr : {r_line, hdump};
    assign w_we0   = r_rd_pend;

    assign buf_ok  = w_buf_ok;
    assign obj_pxl = r_obj_pxl;
    assign line    = r_line;

    // Bank swap and read pipeline: read data is parked in r_pxl_next and
    // shown on the following pxl_cen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lhbl_l     <= 1'b0;
            r_line       <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_erase_addr <= '0;
            r_pxl_next   <= OBJ_BLANK;
            r_obj_pxl    <= OBJ_BLANK;
        end else begin
            r_lhbl_l  <= LHBL;
            r_rd_pend <= 1'b0;
            if (w_hb_fall) r_line <= ~r_line;
            if (r_state == ST_CLEAR) begin
                r_pxl_next <= OBJ_BLANK;
                r_obj_pxl  <= OBJ_BLANK;
            end else begin
                if (r_rd_pend) r_pxl_next <= w_q0;
                if (pxl_cen) begin
                    r_obj_pxl <= r_pxl_next;
                    if (LHBL) begin
                        r_rd_pend    <= 1'b1;
                        r_erase_addr <= {r_line, hdump};
                    end else begin
                        r_pxl_next <= OBJ_BLANK;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
`ifdef JTPANG_OBJBUF_PRIO_EN
            r_chk_addr <= '0;
            r_chk_data <= OBJ_BLANK;
`endif
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_CLEAR) r_clr_addr <= r_clr_addr + 10'd1;
`ifdef JTPANG_OBJBUF_PRIO_EN
            if (r_state == ST_IDLE && buf_we) begin
                r_chk_addr <= w_draw_addr;
                r_chk_data <= buf_data;
            end
`endif
        end
    end

    // Port 1 is shared by the clear sweep and the draw side
    always_comb begin
        w_next_state = r_state;
        w_addr1      = w_draw_addr;
        w_data1      = buf_data;
        w_we1        = 1'b0;
        w_buf_ok     = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_addr1 = r_clr_addr;
                w_data1 = OBJ_BLANK;
                w_we1   = 1'b1;
                if (r_clr_addr == 10'h3FF) w_next_state = ST_IDLE;
            end
            ST_IDLE: begin
                w_buf_ok = 1'b1;
`ifdef JTPANG_OBJBUF_PRIO_EN
                if (buf_we) w_next_state = ST_CHECK;
`else
                w_we1 = buf_we & is_opaque(buf_data);
`endif
            end
`ifdef JTPANG_OBJBUF_PRIO_EN
            // w_q1 holds the word read at acceptance; keep it if already drawn
            ST_CHECK: begin
                w_addr1      = r_chk_addr;
                w_data1      = r_chk_data;
                w_we1        = !is_opaque(w_q1) && is_opaque(r_chk_data);
                w_next_state = ST_IDLE;
            end
`endif
            default: w_next_state = ST_CLEAR;
        endcase
    end

    jtframe_dual_ram #(
        .dw (8),
        .aw (OBJ_RAM_AW)
    ) u_ram (
        .i_clk   (clk),
        .i_addr0 (w_addr0),
        .i_data0 (OBJ_BLANK),
        .i_we0   (w_we0),
        .o_q0    (w_q0),
        .i_addr1 (w_addr1),
        .i_data1 (w_data1),
        .i_we1   (w_we1),
        .o_q1    (w_q1)
    );

endmodule
